// File: rtl/conv_pkg.sv
// Shared definitions for the convolution front end and the dconv engine.
// Pixel/window widths and the window-feeder state encoding live here.
package conv_pkg;

  localparam int PIX_W = 8;
  localparam int WIN_N = 5;
  localparam int WIN_W = PIX_W * WIN_N;

  typedef enum logic [1:0] {
    FILL      = 2'd0,
    STREAM    = 2'd1,
    PAD_LEAD  = 2'd2,
    PAD_TRAIL = 2'd3
  } win_state_t;

endpackage

// File: rtl/pix_shift5.sv
// Five-deep pixel shift register. The parallel output presents the window
// that results from shifting din in, so the owner can register that window
// on the same edge the shift happens. clear zeroes every stage.
module pix_shift5
  import conv_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             shift,
  input  logic             clear,
  input  logic [PIX_W-1:0] din,
  output logic [WIN_W-1:0] win
);

  logic [WIN_W-1:0] taps;

  assign win = {taps[WIN_W-PIX_W-1:0], din};

  // Shift stage: oldest pixel falls off the top, newest enters at the bottom.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      taps <= '0;
    end else if (clear) begin
      taps <= '0;
    end else if (shift) begin
      taps <= win;
    end
  end

endmodule

// File: rtl/conv_window_feeder.sv
// Raster pixel stream to five-pixel horizontal window converter for dconv.
// Optional edge zero-padding is compiled in with the CONV_WIN_PAD_EN macro;
// without it, each row yields IMG_W-4 windows, with it IMG_W windows.
module conv_window_feeder
  import conv_pkg::*;
#(
  parameter int IMG_W = 16,
  parameter int IMG_H = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  output logic             pix_ready,
  output logic [WIN_W-1:0] data,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             row_last,
  output logic             frame_last
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  win_state_t       state, state_nxt;
  logic             run;
  logic [2:0]       fill, fill_nxt;
  logic [COL_W-1:0] col, col_nxt;
  logic [ROW_W-1:0] row, row_nxt;
  logic             out_free;
  logic             accept;
  logic             col_end;
  logic             row_end;
  logic             sh_shift;
  logic             sh_clear;
  logic [PIX_W-1:0] sh_din;
  logic [WIN_W-1:0] sh_win;
  logic             load;
  logic             load_row_last;
  logic             load_frame_last;
`ifdef CONV_WIN_PAD_EN
  logic             trail, trail_nxt;
  logic             frame_end, frame_end_nxt;
`endif

  // The output register can take a new window when empty or being drained.
  // run holds pix_ready low until the first edge after reset releases.
  // PAD_LEAD is a non-accepting cycle, like the two PAD_TRAIL cycles.
  assign out_free  = !data_valid || data_ready;
  assign pix_ready = run && out_free && ((state == FILL) || (state == STREAM));
  assign accept    = pix_valid && pix_ready;
  assign col_end   = (col == COL_LAST);
  assign row_end   = (row == ROW_LAST);

  pix_shift5 u_shift (
    .clk   (clk),
    .rst   (rst),
    .shift (sh_shift),
    .clear (sh_clear),
    .din   (sh_din),
    .win   (sh_win)
  );

  // Next-state, counter and window-load decisions.
  always_comb begin
    state_nxt       = state;
    fill_nxt        = fill;
    col_nxt         = col;
    row_nxt         = row;
    sh_shift        = 1'b0;
    sh_clear        = 1'b0;
    sh_din          = pix_in;
    load            = 1'b0;
    load_row_last   = 1'b0;
    load_frame_last = 1'b0;
`ifdef CONV_WIN_PAD_EN
    trail_nxt       = trail;
    frame_end_nxt   = frame_end;
`endif
    case (state)
      FILL, STREAM: begin
        if (accept) begin
          sh_shift = 1'b1;
          col_nxt  = col_end ? '0 : col + 1'b1;
          if (col_end) begin
            row_nxt = row_end ? '0 : row + 1'b1;
          end
          if ((state == STREAM) || (fill == 3'd4)) begin
            load      = 1'b1;
            state_nxt = STREAM;
          end else begin
            fill_nxt = fill + 3'd1;
          end
          if (col_end) begin
            fill_nxt = 3'd0;
`ifdef CONV_WIN_PAD_EN
            // Row flags move to the second trailing pad window.
            state_nxt     = PAD_TRAIL;
            trail_nxt     = 1'b0;
            frame_end_nxt = row_end;
`else
            load_row_last   = 1'b1;
            load_frame_last = row_end;
            state_nxt       = FILL;
`endif
          end
        end
      end
`ifdef CONV_WIN_PAD_EN
      PAD_TRAIL: begin
        if (out_free) begin
          sh_shift = 1'b1;
          sh_din   = '0;
          load     = 1'b1;
          if (trail) begin
            load_row_last   = 1'b1;
            load_frame_last = frame_end;
            state_nxt       = PAD_LEAD;
          end else begin
            trail_nxt = 1'b1;
          end
        end
      end
      PAD_LEAD: begin
        // A cleared register already holds the two leading zeros.
        sh_clear  = 1'b1;
        fill_nxt  = 3'd2;
        state_nxt = FILL;
      end
`endif
      default: ;
    endcase
  end

  // Control state: FSM, counters and start-up gate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
`ifdef CONV_WIN_PAD_EN
      state     <= PAD_LEAD;
      trail     <= 1'b0;
      frame_end <= 1'b0;
`else
      state     <= FILL;
`endif
      run       <= 1'b0;
      fill      <= 3'd0;
      col       <= '0;
      row       <= '0;
    end else begin
      state     <= state_nxt;
`ifdef CONV_WIN_PAD_EN
      trail     <= trail_nxt;
      frame_end <= frame_end_nxt;
`endif
      run       <= 1'b1;
      fill      <= fill_nxt;
      col       <= col_nxt;
      row       <= row_nxt;
    end
  end

  // Output stage: single register, held while stalled, replaced on load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data       <= '0;
      data_valid <= 1'b0;
      row_last   <= 1'b0;
      frame_last <= 1'b0;
    end else if (load) begin
      data       <= sh_win;
      data_valid <= 1'b1;
      row_last   <= load_row_last;
      frame_last <= load_frame_last;
    end else if (data_ready) begin
      data_valid <= 1'b0;
      row_last   <= 1'b0;
      frame_last <= 1'b0;
    end
  end

endmodule
